// File: rtl/btb_param.sv
// Direct-mapped branch target buffer with 2-bit hysteresis counters and perf counters.
// Lookup is combinational from current state; updates become visible one cycle later.
module btb_param #(
    parameter int         ENTRIES   = 16,
    parameter int         XLEN      = 32,
    parameter logic [1:0] ALLOC_CTR = 2'b10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    input  logic            mispredicted,
    input  logic            flush,
    output logic [XLEN-1:0] target_pc,
    output logic            valid,
    output logic            predictedTaken,
    output logic [31:0]     perf_updates,
    output logic [31:0]     perf_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  tgt;
        logic [1:0]       ctr;
    } entry_t;

    entry_t tbl [ENTRIES];

    logic [IDX_W-1:0] rd_idx, up_idx;
    logic [TAG_W-1:0] rd_tag, up_tag;
    entry_t           rd_ent, up_ent;
    logic             up_hit;
    logic             unused_lsb;

    // Low two address bits never participate in index or tag.
    assign unused_lsb = ^{pc[1:0], update_pc[1:0]};

    assign rd_idx = pc[IDX_W+1:2];
    assign rd_tag = pc[XLEN-1:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[XLEN-1:IDX_W+2];
    assign rd_ent = tbl[rd_idx];
    assign up_ent = tbl[up_idx];
    assign up_hit = up_ent.vld && (up_ent.tag == up_tag);

    assign valid          = rd_ent.vld && (rd_ent.tag == rd_tag);
    assign target_pc      = valid ? rd_ent.tgt : '0;
    assign predictedTaken = valid && rd_ent.ctr[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i].vld <= 1'b0;
                tbl[i].ctr <= 2'b00;
            end
            perf_updates     <= '0;
            perf_mispredicts <= '0;
        end else begin
            // Perf counters see every strobe, even when flush drops the table write.
            if (update) begin
                if (perf_updates != '1)
                    perf_updates <= perf_updates + 32'd1;
                if (mispredicted && perf_mispredicts != '1)
                    perf_mispredicts <= perf_mispredicts + 32'd1;
            end

            if (flush) begin
                for (int i = 0; i < ENTRIES; i++)
                    tbl[i].vld <= 1'b0;
            end else if (update) begin
                if (update_taken) begin
                    if (up_hit) begin
                        if (up_ent.ctr != 2'b11)
                            tbl[up_idx].ctr <= up_ent.ctr + 2'd1;
                        tbl[up_idx].tgt <= update_target;
                    end else begin
                        tbl[up_idx].vld <= 1'b1;
                        tbl[up_idx].tag <= up_tag;
                        tbl[up_idx].tgt <= update_target;
                        tbl[up_idx].ctr <= ALLOC_CTR;
                    end
                end else if (up_hit && up_ent.ctr != 2'b00) begin
                    tbl[up_idx].ctr <= up_ent.ctr - 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_btb_param.sv
// Directed test of btb_param (ENTRIES=16): allocation, hysteresis, aliasing,
// flush priority, perf counters and mid-operation reset.
module tb_btb_param;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, update_pc, update_target;
    logic        update, update_taken, mispredicted, flush;
    logic [31:0] target_pc;
    logic        valid, predictedTaken;
    logic [31:0] perf_updates, perf_mispredicts;

    int total = 0;
    int bad   = 0;

    btb_param #(.ENTRIES(16), .XLEN(32), .ALLOC_CTR(2'b10)) dut (
        .clk(clk), .rst(rst), .pc(pc), .update_pc(update_pc), .update(update),
        .update_taken(update_taken), .update_target(update_target),
        .mispredicted(mispredicted), .flush(flush), .target_pc(target_pc),
        .valid(valid), .predictedTaken(predictedTaken),
        .perf_updates(perf_updates), .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    // Present one update strobe, take the edge, then drop it.
    task automatic upd(input logic [31:0] a, input logic t, input logic [31:0] tg, input logic m);
        update_pc = a; update_taken = t; update_target = tg; mispredicted = m; update = 1'b1;
        @(posedge clk); #1;
        update = 1'b0; mispredicted = 1'b0;
    endtask

    task automatic look(input logic [31:0] a);
        pc = a; #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; pc = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        total++; if (predictedTaken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%0b exp=0", predictedTaken); end
        total++; if (target_pc !== 32'h0) begin bad++; $display("FAIL reset_target got=%h exp=0", target_pc); end
        total++; if (perf_updates !== 32'd0) begin bad++; $display("FAIL reset_perf_upd got=%0d exp=0", perf_updates); end
        total++; if (perf_mispredicts !== 32'd0) begin bad++; $display("FAIL reset_perf_mis got=%0d exp=0", perf_mispredicts); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alloc;
        pc = 32'h100;
        update_pc = 32'h100; update_taken = 1'b1; update_target = 32'h200; update = 1'b1;
        #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL same_cycle_valid got=%0b exp=0", valid); end
        @(posedge clk); #1;
        update = 1'b0;
        look(32'h100);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL alloc_valid got=%0b exp=1", valid); end
        total++; if (target_pc !== 32'h200) begin bad++; $display("FAIL alloc_target got=%h exp=200", target_pc); end
        total++; if (predictedTaken !== 1'b1) begin bad++; $display("FAIL alloc_taken got=%0b exp=1", predictedTaken); end
        total++; if (perf_updates !== 32'd1) begin bad++; $display("FAIL alloc_perf got=%0d exp=1", perf_updates); end
    endtask

    task automatic test_hysteresis;
        logic        t_seq [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        p_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] g_seq [8] = '{32'h999, 32'h999, 32'h200, 32'h204, 32'h208, 32'h20C, 32'h777, 32'h777};
        logic [31:0] x_tgt [8] = '{32'h200, 32'h200, 32'h200, 32'h204, 32'h208, 32'h20C, 32'h20C, 32'h20C};
        // Counter path: 10 ->01 ->00 ->01 ->10 ->11 ->11(sat) ->10 ->01
        for (int i = 0; i < 8; i++) begin
            upd(32'h100, t_seq[i], g_seq[i], 1'b0);
            look(32'h100);
            total++; if (valid !== 1'b1) begin bad++; $display("FAIL hyst_valid step=%0d got=%0b exp=1", i, valid); end
            total++; if (predictedTaken !== p_exp[i]) begin bad++; $display("FAIL hyst_taken step=%0d got=%0b exp=%0b", i, predictedTaken, p_exp[i]); end
            total++; if (target_pc !== x_tgt[i]) begin bad++; $display("FAIL hyst_target step=%0d got=%h exp=%h", i, target_pc, x_tgt[i]); end
        end
        total++; if (perf_updates !== 32'd9) begin bad++; $display("FAIL hyst_perf got=%0d exp=9", perf_updates); end
    endtask

    task automatic test_alias;
        look(32'h140);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL alias_pre got=%0b exp=0", valid); end
        upd(32'h140, 1'b1, 32'h300, 1'b0);
        look(32'h140);
        total++; if (valid !== 1'b1 || target_pc !== 32'h300 || predictedTaken !== 1'b1)
            begin bad++; $display("FAIL alias_hit got=%0b/%h/%0b exp=1/300/1", valid, target_pc, predictedTaken); end
        look(32'h100);
        total++; if (valid !== 1'b0 || target_pc !== 32'h0) begin bad++; $display("FAIL alias_evict got=%0b/%h exp=0/0", valid, target_pc); end
        upd(32'h180, 1'b0, 32'h400, 1'b0);
        look(32'h180);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL nt_noalloc got=%0b exp=0", valid); end
        look(32'h140);
        total++; if (valid !== 1'b1 || predictedTaken !== 1'b1) begin bad++; $display("FAIL nt_keep got=%0b/%0b exp=1/1", valid, predictedTaken); end
    endtask

    task automatic test_flush;
        upd(32'h104, 1'b1, 32'h500, 1'b0);
        look(32'h104);
        total++; if (valid !== 1'b1 || target_pc !== 32'h500) begin bad++; $display("FAIL idx1_alloc got=%0b/%h exp=1/500", valid, target_pc); end
        flush = 1'b1;
        upd(32'h1C0, 1'b1, 32'h600, 1'b0);
        flush = 1'b0;
        look(32'h140);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL flush_140 got=%0b exp=0", valid); end
        look(32'h104);
        total++; if (valid !== 1'b0 || target_pc !== 32'h0) begin bad++; $display("FAIL flush_104 got=%0b/%h exp=0/0", valid, target_pc); end
        look(32'h1C0);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL flush_1c0 got=%0b exp=0", valid); end
        total++; if (perf_updates !== 32'd13) begin bad++; $display("FAIL flush_perf got=%0d exp=13", perf_updates); end
    endtask

    task automatic test_perf;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        upd(32'h800, 1'b0, 32'h0, 1'b1);
        upd(32'h800, 1'b0, 32'h0, 1'b0);
        upd(32'h800, 1'b0, 32'h0, 1'b1);
        mispredicted = 1'b1; @(posedge clk); #1; mispredicted = 1'b0;
        total++; if (perf_updates !== 32'd3) begin bad++; $display("FAIL perf_upd got=%0d exp=3", perf_updates); end
        total++; if (perf_mispredicts !== 32'd2) begin bad++; $display("FAIL perf_mis got=%0d exp=2", perf_mispredicts); end
    endtask

    task automatic test_mid_reset;
        upd(32'h100, 1'b1, 32'h200, 1'b1);
        upd(32'h100, 1'b1, 32'h200, 1'b0);
        rst = 1'b1;
        upd(32'h140, 1'b1, 32'h300, 1'b1);
        rst = 1'b0;
        look(32'h100);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_100 got=%0b exp=0", valid); end
        look(32'h140);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_140 got=%0b exp=0", valid); end
        total++; if (perf_updates !== 32'd0 || perf_mispredicts !== 32'd0)
            begin bad++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", perf_updates, perf_mispredicts); end
        // Fresh allocation after reset starts from the allocation counter, not the old 11.
        upd(32'h100, 1'b1, 32'h220, 1'b0);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        total++; if (valid !== 1'b1 || predictedTaken !== 1'b0 || target_pc !== 32'h220)
            begin bad++; $display("FAIL rst_realloc got=%0b/%0b/%h exp=1/0/220", valid, predictedTaken, target_pc); end
    endtask

    initial begin
        rst = 1'b1; pc = '0; update_pc = '0; update_target = '0;
        update = 1'b0; update_taken = 1'b0; mispredicted = 1'b0; flush = 1'b0;
        @(negedge clk);
        test_reset;
        test_alloc;
        test_hysteresis;
        test_alias;
        test_flush;
        test_perf;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
